// File: rtl/image_dram_reader_if.sv
// Read-side bus bundle for image_dram_reader.
// Carries the DRAM read port (mem_re/mem_addr/mem_rdata) and the pixel stream
// (px_data/px_valid/px_ready/px_last) toward the filter datapath.
//   master : the reader (drives reads and the pixel stream)
//   slave  : the DRAM + consumer side
interface image_dram_reader_if #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 16
) ();
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] px_data;
  logic          px_valid;
  logic          px_ready;
  logic          px_last;

  modport master (
    output mem_re, mem_addr, px_data, px_valid, px_last,
    input  mem_rdata, px_ready
  );

  modport slave (
    input  mem_re, mem_addr, px_data, px_valid, px_last,
    output mem_rdata, px_ready
  );
endinterface

// File: rtl/image_dram_reader.sv
// image_dram_reader: streams pix_count consecutive DW-bit pixels from base_addr
// out of the image DRAM, one synchronous read per cycle, buffered in a 2-entry
// FIFO and delivered on a valid/ready stream.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               job request, sampled only in IDLE
//   base_addr/pix_count job parameters, latched on accepted start
//   busy                high in RUN and DRAIN
//   done                one-cycle pulse at end of job
//   bus (master)        mem_re/mem_addr/mem_rdata + px_data/px_valid/px_ready/px_last
//   stall_cycles        only with IMG_READER_PERF_EN: cycles busy with px_valid & !px_ready
// Optional feature macro: IMG_READER_PERF_EN
module image_dram_reader #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [AW-1:0]       base_addr,
  input  logic [AW-1:0]       pix_count,
  output logic                busy,
  output logic                done,
`ifdef IMG_READER_PERF_EN
  output logic [31:0]         stall_cycles,
`endif
  image_dram_reader_if.master bus
);

  localparam int unsigned FDEPTH = 2;
  localparam int unsigned CW     = 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [AW-1:0] base_q, count_q, issued_q, head_idx_q, last_addr_q;
  logic          inflight_q;
  logic [DW-1:0] fifo_q [FDEPTH];
  logic          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] fifo_cnt_q;
  logic [DW-1:0] hold_q;

  logic          pop, push, mem_re_c, px_valid_c, px_last_c;
  logic [AW-1:0] mem_addr_c;
  logic [CW:0]   occ;

  // Read credit, address generation and stream outputs
  always_comb begin
    px_valid_c = (fifo_cnt_q != '0);
    pop        = px_valid_c & bus.px_ready;
    push       = inflight_q;
    // Slots committed after this cycle: stored + returning - leaving
    occ        = (CW+1)'(fifo_cnt_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    mem_re_c   = (state == RUN) && (issued_q < count_q) && (occ < (CW+1)'(FDEPTH));
    mem_addr_c = mem_re_c ? (base_q + issued_q) : last_addr_q;
    px_last_c  = px_valid_c && (head_idx_q == count_q - AW'(1));
  end

  assign bus.mem_re   = mem_re_c;
  assign bus.mem_addr = mem_addr_c;
  assign bus.px_valid = px_valid_c;
  assign bus.px_last  = px_last_c;
  // Empty FIFO shows the last popped pixel rather than a stale slot
  assign bus.px_data  = px_valid_c ? fifo_q[rd_ptr_q] : hold_q;
  assign busy         = (state == RUN) || (state == DRAIN);
  assign done         = (state == DONE);

  // Sequencer FSM, read counters and FIFO storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      head_idx_q  <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      fifo_cnt_q  <= '0;
      hold_q      <= '0;
      for (int i = 0; i < int'(FDEPTH); i++) fifo_q[i] <= '0;
    end else begin
      inflight_q <= mem_re_c;
      if (mem_re_c) begin
        issued_q    <= issued_q + AW'(1);
        last_addr_q <= mem_addr_c;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.mem_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q   <= ~rd_ptr_q;
        hold_q     <= fifo_q[rd_ptr_q];
        head_idx_q <= head_idx_q + AW'(1);
      end
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);

      case (state)
        IDLE: if (start) begin
          base_q     <= base_addr;
          count_q    <= pix_count;
          issued_q   <= '0;
          head_idx_q <= '0;
          state      <= (pix_count != '0) ? RUN : DONE;
        end
        RUN:   if (mem_re_c && (issued_q == count_q - AW'(1))) state <= DRAIN;
        DRAIN: if (pop && px_last_c) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMG_READER_PERF_EN
  // Saturating back-pressure counter, cleared by each accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cycles <= '0;
    end else if (busy && px_valid_c && !bus.px_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

  // Credit rule must make a push into a full, non-draining FIFO impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (fifo_cnt_q == CW'(FDEPTH)) && !pop));

endmodule

// File: tb/tb_image_dram_reader.sv
module tb_image_dram_reader;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] pix_count;
  logic          busy;
  logic          done;
`ifdef IMG_READER_PERF_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   stall_at_done;
`endif

  image_dram_reader_if #(.AW(AW), .DW(DW)) dif ();

  image_dram_reader #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .pix_count    (pix_count),
    .busy         (busy),
    .done         (done),
`ifdef IMG_READER_PERF_EN
    .stall_cycles (stall_cycles),
`endif
    .bus          (dif.master)
  );

  always #5 clk = ~clk;

  // DRAM contents: pixel at address a is a+111 (truncated to DW)
  function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
    return DW'(a + AW'(111));
  endfunction

  // Synchronous DRAM model: data valid the cycle after mem_re
  always @(posedge clk) begin
    if (dif.mem_re) dif.mem_rdata <= pix(dif.mem_addr);
  end

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] exp_addr_q [$];
  logic [DW:0]   exp_px_q   [$];   // {last, data}

  int cyc, first_re, first_valid, last_xfer, done_cyc, n_done, n_xfer, outst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      1:       return (c % 3) == 0;
      2:       return !(c >= 3 && c <= 7);
      default: return 1'b1;
    endcase
  endfunction

  // One clock: monitor/scoreboard at negedge, then step past the next posedge
  task automatic tick();
    logic       pop;
    logic [DW:0] e;
    @(negedge clk);
    if (rst_n) begin
      pop = dif.px_valid & dif.px_ready;
      if (dif.mem_re) begin
        if (first_re < 0) first_re = cyc;
        chk("credit", 32'(outst + 1 - int'(pop) <= 2), 32'd1);
        chk("read_expected", 32'(exp_addr_q.size() != 0), 32'd1);
        if (exp_addr_q.size() != 0) chk("mem_addr", 32'(dif.mem_addr), 32'(exp_addr_q.pop_front()));
        outst++;
      end
      if (dif.px_valid && first_valid < 0) first_valid = cyc;
      if (pop) begin
        chk("px_expected", 32'(exp_px_q.size() != 0), 32'd1);
        if (exp_px_q.size() != 0) begin
          e = exp_px_q.pop_front();
          chk("px_data", 32'(dif.px_data), 32'(e[DW-1:0]));
          chk("px_last", 32'(dif.px_last), 32'(e[DW]));
        end
        outst--;
        n_xfer++;
        last_xfer = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
`ifdef IMG_READER_PERF_EN
        stall_at_done = stall_cycles;
`endif
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_book();
    exp_addr_q.delete();
    exp_px_q.delete();
    cyc = 0; first_re = -1; first_valid = -1; last_xfer = -1;
    done_cyc = -1; n_done = 0; n_xfer = 0; outst = 0;
  endtask

  task automatic launch(input logic [AW-1:0] b, input int cnt, input int mode);
    clear_book();
    for (int i = 0; i < cnt; i++) begin
      exp_addr_q.push_back(b + AW'(i));
      exp_px_q.push_back({(i == cnt - 1), pix(b + AW'(i))});
    end
    start     = 1'b1;
    base_addr = b;
    pix_count = AW'(cnt);
    dif.px_ready = rdy(mode, 0);
    tick();
    start = 1'b0;
  endtask

  task automatic run_job(input string nm, input logic [AW-1:0] b, input int cnt, input int mode);
    launch(b, cnt, mode);
    while (n_done == 0 && cyc < 200) begin
      dif.px_ready = rdy(mode, cyc);
      tick();
    end
    chk({nm, "_done_seen"}, 32'(n_done), 32'd1);
    chk({nm, "_n_xfer"}, 32'(n_xfer), 32'(cnt));
    chk({nm, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
    chk({nm, "_px_left"}, 32'(exp_px_q.size()), 32'd0);
    if (cnt > 0) begin
      chk({nm, "_first_re"}, 32'(first_re), 32'd1);
      chk({nm, "_first_valid"}, 32'(first_valid), 32'd3);
      chk({nm, "_done_after_last"}, 32'(done_cyc), 32'(last_xfer + 1));
      if (mode == 0) chk({nm, "_last_xfer"}, 32'(last_xfer), 32'(2 + cnt));
    end else begin
      chk({nm, "_done_cyc"}, 32'(done_cyc), 32'd1);
      chk({nm, "_no_re"}, 32'(first_re), 32'hFFFF_FFFF);
      chk({nm, "_no_valid"}, 32'(first_valid), 32'hFFFF_FFFF);
    end
    dif.px_ready = 1'b1;
    tick();
    chk({nm, "_done_once"}, 32'(n_done), 32'd1);
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
    chk({nm, "_idle_valid"}, 32'(dif.px_valid), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_busy"},     32'(busy),         32'd0);
    chk({nm, "_done"},     32'(done),         32'd0);
    chk({nm, "_mem_re"},   32'(dif.mem_re),   32'd0);
    chk({nm, "_mem_addr"}, 32'(dif.mem_addr), 32'd0);
    chk({nm, "_px_valid"}, 32'(dif.px_valid), 32'd0);
    chk({nm, "_px_last"},  32'(dif.px_last),  32'd0);
    chk({nm, "_px_data"},  32'(dif.px_data),  32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; pix_count = '0;
    dif.px_ready = 1'b0;
    clear_book();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // T1: base 0, 10 pixels, consumer always ready
    run_job("t1", AW'(0), 10, 0);
    // T2: back-pressure pattern 1,0,0,1,...
    run_job("t2", AW'('h40), 4, 1);
    // T3: address wraps past the top of the address space
    run_job("t3", AW'('h3FFFE), 4, 0);
    // T4: empty job
    run_job("t4", AW'('h10), 0, 0);

    // T5: asynchronous reset after the 3rd pixel of a 10-pixel job
    launch(AW'('h100), 10, 0);
    while (n_xfer < 3 && cyc < 50) begin
      dif.px_ready = 1'b1;
      tick();
    end
    chk("t5_reached_third", 32'(n_xfer), 32'd3);
    rst_n = 1'b0;
    clear_book();
    @(negedge clk);
    chk_outputs_zero("t5_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("t5_no_done", 32'(n_done), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    run_job("t5_restart", AW'('h200), 2, 0);

    // T6: consumer stalls 5 cycles after first px_valid
    run_job("t6", AW'('h80), 3, 2);
`ifdef IMG_READER_PERF_EN
    chk("t6_stall_cycles", stall_at_done, 32'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
